// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one-cycle-latency word reads and buffers
// {pc, inst} pairs for decode; a redirect flushes everything in flight.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h4000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   localparam int unsigned AW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = BUF_DEPTH[CW:0];

   logic [31:0]   r_pc;
   logic [31:0]   r_req_addr;
   logic          r_inflight;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_buf_inst [BUF_DEPTH];
   logic [31:0]   r_buf_pc   [BUF_DEPTH];

   logic          w_has_data;
   logic          w_pop;
   logic          w_wr;
   logic          w_issue;
   logic [CW:0]   w_occupancy;

   // Occupancy counts the response landing at this edge, so the buffer can never overflow.
   always_comb begin
      w_has_data  = (r_count != '0);
      w_pop       = w_has_data && inst_ready && !redirect_valid;
      w_wr        = r_inflight && !redirect_valid;
      w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
      w_issue     = !rst && !redirect_valid && (w_occupancy < DEPTH_C);
   end

   always_comb begin
      imem_req   = w_issue;
      imem_addr  = r_pc;
      inst_valid = w_has_data;
      inst       = w_has_data ? r_buf_inst[r_rd_ptr] : '0;
      inst_pc    = w_has_data ? r_buf_pc[r_rd_ptr]   : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= {RESET_PC[31:2], 2'b00};
         r_req_addr <= '0;
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[31:2], 2'b00};
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_issue) begin
            r_pc       <= r_pc + 32'd4;
            r_req_addr <= r_pc;
         end
         r_inflight <= w_issue;
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_wr && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_buf_inst[r_wr_ptr] <= imem_rdata;
         r_buf_pc[r_wr_ptr]   <= r_req_addr;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of expected PCs checked on every decode handshake,
// plus timing checks for reset, stall, redirect and PC wrap.
module tb_fetch_stage;
   localparam logic [31:0] RST_PC  = 32'h4000_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        redirect_valid, redirect_valid2;
   logic [31:0] redirect_pc, redirect_pc2;
   logic        inst_valid, inst_valid2;
   logic [31:0] inst, inst2;
   logic [31:0] inst_pc, inst_pc2;
   logic        inst_ready, inst_ready2;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp2_q[$];

   fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready));

   fetch_stage #(.RESET_PC(WRAP_PC), .BUF_DEPTH(2)) dut2 (
      .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
      .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_ready(inst_ready2));

   always #5 clk = ~clk;

   // Memory content is a scramble of the address so pc/inst swaps are visible.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) begin
      imem_rdata  <= imem_req  ? memf(imem_addr)  : 32'hDEAD_BEEF;
      imem_rdata2 <= imem_req2 ? memf(imem_addr2) : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(dut.r_inflight && !redirect_valid && dut.r_count == 2'd2))
         else begin
            errors++;
            $display("FAIL fifo_overflow: write into full buffer, count=%0d", dut.r_count);
         end
      end
   end

   task automatic sb_load(input logic [31:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst2 = 1'b1;
      inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      inst_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = '0;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         checks++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h, want 0 0 0 0",
                     imem_req, inst_valid, inst, inst_pc);
         end
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      logic [31:0] exp_addr;
      rst = 1'b0; inst_ready = 1'b1;
      sb_load(RST_PC, 64);
      exp_addr = RST_PC;
      for (int c = 0; c < 12; c++) begin
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL stream_issue: cycle %0d req=%b addr=%h, want 1 %h", c, imem_req, imem_addr, exp_addr);
         end
         exp_addr = exp_addr + 32'd4;
         checks++;
         if (inst_valid !== (c >= 2)) begin
            errors++;
            $display("FAIL stream_valid: cycle %0d valid=%b, want %b", c, inst_valid, (c >= 2));
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stream_sb: unexpected pc=%h, want none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e || inst !== memf(e)) begin
                  errors++;
                  $display("FAIL stream_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc, inst, e, memf(e));
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_stall();
      logic [31:0] e;
      inst_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d req=%b valid=%b, want 0 1", c, imem_req, inst_valid);
         end
         next_cycle();
      end
      checks++;
      if (dut.r_count !== 2'd2) begin
         errors++; $display("FAIL stall_count: count=%0d, want 2", dut.r_count);
      end
      inst_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++;
         if (inst_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release_valid: cycle %0d valid=%b, want 1", c, inst_valid);
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stall_sb: unexpected pc=%h, want none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e || inst !== memf(e)) begin
                  errors++;
                  $display("FAIL stall_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc, inst, e, memf(e));
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect_full();
      logic [31:0] e;
      inst_ready = 1'b0;
      repeat (4) next_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h4000_0103;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
         errors++; $display("FAIL redir_full_T: req=%b valid=%b, want 0 1", imem_req, inst_valid);
      end
      next_cycle();
      redirect_valid = 1'b0; inst_ready = 1'b1;
      sb_load(32'h4000_0100, 32);
      for (int c = 1; c < 8; c++) begin
         #1;
         if (c == 1) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0100) begin
               errors++; $display("FAIL redir_full_req: req=%b addr=%h, want 1 40000100", imem_req, imem_addr);
            end
         end
         checks++;
         if (inst_valid !== (c >= 3)) begin
            errors++; $display("FAIL redir_full_valid: T+%0d valid=%b, want %b", c, inst_valid, (c >= 3));
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL redir_full_sb: unexpected pc=%h, want none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e || inst !== memf(e)) begin
                  errors++;
                  $display("FAIL redir_full_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc, inst, e, memf(e));
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect_pop();
      logic [31:0] e;
      inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h4000_2000;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || dut.r_inflight !== 1'b1) begin
         errors++;
         $display("FAIL redir_pop_T: req=%b valid=%b inflight=%b, want 0 1 1", imem_req, inst_valid, dut.r_inflight);
      end
      next_cycle();
      redirect_valid = 1'b0;
      sb_load(32'h4000_2000, 32);
      for (int c = 1; c < 9; c++) begin
         #1;
         if (c == 1) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4000_2000) begin
               errors++; $display("FAIL redir_pop_req: req=%b addr=%h, want 1 40002000", imem_req, imem_addr);
            end
         end
         checks++;
         if (inst_valid !== (c >= 3)) begin
            errors++; $display("FAIL redir_pop_valid: T+%0d valid=%b, want %b", c, inst_valid, (c >= 3));
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL redir_pop_sb: unexpected pc=%h, want none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e || inst !== memf(e)) begin
                  errors++;
                  $display("FAIL redir_pop_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc, inst, e, memf(e));
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h4000_3000;
      next_cycle();
      redirect_pc = 32'h4000_5006;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_second: req=%b valid=%b, want 0 0", imem_req, inst_valid);
      end
      next_cycle();
      redirect_valid = 1'b0;
      sb_load(32'h4000_5004, 32);
      for (int c = 1; c < 8; c++) begin
         #1;
         if (c == 1) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4000_5004) begin
               errors++; $display("FAIL b2b_req: req=%b addr=%h, want 1 40005004", imem_req, imem_addr);
            end
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_sb: unexpected pc=%h, want none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e || inst !== memf(e)) begin
                  errors++;
                  $display("FAIL b2b_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc, inst, e, memf(e));
               end
            end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 27) begin
         errors++; $display("FAIL b2b_count: delivered=%0d, want 5", 32 - exp_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] e;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL rst_async: req=%b valid=%b, want 0 0", imem_req, inst_valid);
      end
      next_cycle();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL rst_hold: req=%b valid=%b, want 0 0", imem_req, inst_valid);
      end
      rst = 1'b0;
      sb_load(RST_PC, 32);
      for (int c = 0; c < 7; c++) begin
         #1;
         if (c == 0) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
               errors++; $display("FAIL rst_restart: req=%b addr=%h, want 1 %h", imem_req, imem_addr, RST_PC);
            end
         end
         checks++;
         if (inst_valid !== (c >= 2)) begin
            errors++; $display("FAIL rst_restart_valid: cycle %0d valid=%b, want %b", c, inst_valid, (c >= 2));
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rst_sb: unexpected pc=%h, want none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc !== e || inst !== memf(e)) begin
                  errors++;
                  $display("FAIL rst_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc, inst, e, memf(e));
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      int delivered;
      delivered = 0;
      exp2_q.delete();
      for (int i = 0; i < 8; i++) exp2_q.push_back(WRAP_PC + 32'(4 * i));
      rst2 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (inst_valid2 && inst_ready2) begin
            checks++;
            delivered++;
            if (exp2_q.size() == 0) begin
               errors++; $display("FAIL wrap_sb: unexpected pc=%h, want none", inst_pc2);
            end else begin
               e = exp2_q.pop_front();
               if (inst_pc2 !== e || inst2 !== memf(e)) begin
                  errors++;
                  $display("FAIL wrap_sb: pc=%h inst=%h, want pc=%h inst=%h", inst_pc2, inst2, e, memf(e));
               end
            end
         end
         next_cycle();
      end
      checks++;
      if (delivered != 6) begin
         errors++; $display("FAIL wrap_count: delivered=%0d, want 6", delivered);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_redirect_pop();
      test_back_to_back();
      test_reset_midstream();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
